// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port data memory.
// The arbiter uses the slave modport; requesters and memory together form the master side.
interface dmem_arbiter_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          done0;
  logic          err0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          done1;
  logic          err1;
  logic [DW-1:0] rdata1;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    output gnt0, done0, err0, rdata0, gnt1, done1, err1, rdata1,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    input  gnt0, done0, err0, rdata0, gnt1, done1, err1, rdata1,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: IDLE -> ACCESS -> RESPONSE per access.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 11
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit LP_RR = 1'b1;
`else
  localparam bit LP_RR = 1'b0;
`endif
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACCESS   = 2'd1,
    S_RESPONSE = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_last;
  logic          r_win;
  logic          r_we;
  logic          r_legal;
  logic          r_gnt0, r_gnt1;
  logic          r_done0, r_done1;
  logic          r_err0, r_err1;
  logic [DW-1:0] r_rdata0, r_rdata1;
  logic          r_mem_en, r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;

  logic          w_any;
  logic          w_pick1;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;
  logic          w_sel_legal;

  // Winner selection; the pointer only matters when both ports contend in round-robin mode.
  always_comb begin
    w_any       = bus.req0 | bus.req1;
    w_pick1     = LP_RR ? (bus.req1 & (~bus.req0 | ~r_last))
                        : (bus.req1 & ~bus.req0);
    w_sel_we    = w_pick1 ? bus.we1    : bus.we0;
    w_sel_addr  = w_pick1 ? bus.addr1  : bus.addr0;
    w_sel_wdata = w_pick1 ? bus.wdata1 : bus.wdata0;
    w_sel_legal = ({1'b0, w_sel_addr} < LP_DEPTH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_win       <= 1'b0;
      r_we        <= 1'b0;
      r_legal     <= 1'b0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_win   <= w_pick1;
            r_we    <= w_sel_we;
            r_legal <= w_sel_legal;
            r_gnt0  <= ~w_pick1;
            r_gnt1  <= w_pick1;
            // Out-of-range accesses never strobe the memory.
            if (w_sel_legal) begin
              r_mem_en    <= 1'b1;
              r_mem_we    <= w_sel_we;
              r_mem_addr  <= w_sel_addr;
              r_mem_wdata <= w_sel_wdata;
            end
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_last  <= r_win;
          r_done0 <= ~r_win;
          r_done1 <= r_win;
          r_err0  <= ~r_win & ~r_legal;
          r_err1  <= r_win & ~r_legal;
          r_state <= S_RESPONSE;
        end
        S_RESPONSE: begin
          // Memory read data is valid this cycle; rejected reads return zero.
          if (!r_we) begin
            if (r_win) r_rdata1 <= r_legal ? bus.mem_rdata : '0;
            else       r_rdata0 <= r_legal ? bus.mem_rdata : '0;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt0      = r_gnt0;
  assign bus.gnt1      = r_gnt1;
  assign bus.done0     = r_done0;
  assign bus.done1     = r_done1;
  assign bus.err0      = r_err0;
  assign bus.err1      = r_err1;
  assign bus.rdata0    = r_rdata0;
  assign bus.rdata1    = r_rdata1;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule
